// File: rtl/uart_fpu_sequencer.sv
// uart_fpu_sequencer: collects a 9-byte opcode/operand frame from a UART receiver,
// runs one FPU operation and streams the 32-bit result (or an error byte) back out.
module uart_fpu_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_busy,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        busy,
    output logic        err
);
    localparam logic [2:0] RX         = 3'd0;
    localparam logic [2:0] CHECK      = 3'd1;
    localparam logic [2:0] START      = 3'd2;
    localparam logic [2:0] WAIT_FPU   = 3'd3;
    localparam logic [2:0] TX_LOAD    = 3'd4;
    localparam logic [2:0] TX_WAIT_HI = 3'd5;
    localparam logic [2:0] TX_WAIT_LO = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] idle_q, idle_d;
    logic        rx_busy_d_q;
    logic [71:0] frame_q, frame_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  len_q, len_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        err_q, err_d;
    logic [1:0]  fpu_op_q, fpu_op_d;
    logic [31:0] fpu_a_q, fpu_a_d;
    logic [31:0] fpu_b_q, fpu_b_d;
    logic        strobe;

    assign strobe    = rx_busy_d_q & ~rx_busy;
    assign busy      = (state_q != RX) | (cnt_q != 4'd0);
    assign fpu_start = state_q == START;
    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign err       = err_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        frame_d   = frame_q;
        resp_d    = resp_q;
        len_d     = len_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        err_d     = 1'b0;
        fpu_op_d  = fpu_op_q;
        fpu_a_d   = fpu_a_q;
        fpu_b_d   = fpu_b_q;
        case (state_q)
            RX: begin
                // bytes arrive in order, so shifting in is equivalent to indexing by count
                if (strobe) begin
                    frame_d = {frame_q[63:0], rx_data};
                    idle_d  = 24'd0;
                    cnt_d   = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd8) ? CHECK : RX;
                end else if (cnt_q != 4'd0) begin
                    if (idle_q == TIMEOUT_CYCLES - 24'd1) begin
                        cnt_d  = 4'd0;
                        idle_d = 24'd0;
                        err_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + 24'd1;
                    end
                end else begin
                    idle_d = 24'd0;
                end
            end
            CHECK: begin
                if (frame_q[71:66] != 6'd0) begin
                    err_d   = 1'b1;
                    resp_d  = {ERR_BYTE, 24'd0};
                    len_d   = 3'd1;
                    state_d = TX_LOAD;
                end else begin
                    fpu_op_d = frame_q[65:64];
                    fpu_a_d  = frame_q[63:32];
                    fpu_b_d  = frame_q[31:0];
                    state_d  = START;
                end
            end
            START: state_d = WAIT_FPU;
            WAIT_FPU: begin
                if (fpu_done) begin
                    resp_d  = fpu_result;
                    len_d   = 3'd4;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!tx_busy) begin
                    tx_data_d = resp_q[31:24];
                    tx_en_d   = 1'b1;
                    resp_d    = {resp_q[23:0], 8'd0};
                    state_d   = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: state_d = tx_busy ? TX_WAIT_LO : TX_WAIT_HI;
            TX_WAIT_LO: begin
                if (!tx_busy) begin
                    len_d   = len_q - 3'd1;
                    state_d = (len_q == 3'd1) ? RX : TX_LOAD;
                end
            end
            default: state_d = RX;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RX;
            cnt_q       <= 4'd0;
            idle_q      <= 24'd0;
            rx_busy_d_q <= 1'b0;
            frame_q     <= 72'd0;
            resp_q      <= 32'd0;
            len_q       <= 3'd0;
            tx_data_q   <= 8'd0;
            tx_en_q     <= 1'b0;
            err_q       <= 1'b0;
            fpu_op_q    <= 2'd0;
            fpu_a_q     <= 32'd0;
            fpu_b_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            rx_busy_d_q <= rx_busy;
            frame_q     <= frame_d;
            resp_q      <= resp_d;
            len_q       <= len_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            err_q       <= err_d;
            fpu_op_q    <= fpu_op_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
        end
    end
endmodule

// File: doc/uart_fpu_sequencer.md
UART_FPU_SEQUENCER -- requirements
Module: uart_fpu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1_000_000, meaning the inter-byte receive timeout in clk cycles.
REQ-002 SHALL have parameter ERR_BYTE, default 8'hEE, meaning the response byte sent for an invalid opcode.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: byte from the UART receiver data_out.
REQ-006 SHALL have port rx_busy, input, 1 bit: receiver busy; its falling edge marks rx_data valid.
REQ-007 SHALL have port tx_busy, input, 1 bit: transmitter busy.
REQ-008 SHALL have port tx_data, output, 8 bits: byte to the transmitter data_in.
REQ-009 SHALL have port tx_en, output, 1 bit: one-cycle transmit request.
REQ-010 SHALL have port fpu_op, output, 2 bits: 0 = add, 1 = sub, 2 = mul, 3 = div.
REQ-011 SHALL have ports fpu_a and fpu_b, outputs, 32 bits each: IEEE-754 single-precision operands.
REQ-012 SHALL have port fpu_start, output, 1 bit: one-cycle start pulse to the FPU.
REQ-013 SHALL have port fpu_done, input, 1 bit: FPU result-valid pulse.
REQ-014 SHALL have port fpu_result, input, 32 bits: FPU result, valid while fpu_done = 1.
REQ-015 SHALL have port busy, output, 1 bit: 1 whenever state != RX or byte count != 0.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse on a timeout or an invalid opcode.

Function
REQ-017 SHALL detect a byte strobe as rx_busy_d & ~rx_busy, where rx_busy_d is rx_busy registered once.
REQ-018 SHALL use the frame: byte0 = opcode; bytes 1-4 = fpu_a, MSB first; bytes 5-8 = fpu_b, MSB first.
REQ-019 SHALL implement the states RX, CHECK, START, WAIT_FPU, TX_LOAD, TX_WAIT_HI and TX_WAIT_LO.
REQ-020 In RX, SHALL store each strobed byte into the frame register indexed by a 4-bit count, then increment the count.
REQ-021 In RX, when the 9th byte is stored, SHALL clear the count and go to CHECK on the next cycle.
REQ-022 SHALL count idle cycles in RX while count != 0, and reset that counter on every strobe.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES-1, SHALL clear the count, discard the partial frame, stay in RX and pulse err.
REQ-024 SHALL NOT raise a timeout while count = 0.
REQ-025 In CHECK, if opcode[7:2] != 0, SHALL pulse err, load ERR_BYTE as a single-byte response and go to TX_LOAD.
REQ-026 In CHECK, if opcode[7:2] = 0, SHALL drive fpu_op = opcode[1:0] and update fpu_a/fpu_b, then go to START.
REQ-027 SHALL hold fpu_a, fpu_b and fpu_op stable from START until the next CHECK.
REQ-028 In START, SHALL assert fpu_start for exactly one cycle, then go to WAIT_FPU.
REQ-029 In WAIT_FPU, SHALL latch fpu_result into a 32-bit shift register on fpu_done and set the response length to 4 bytes.
REQ-030 SHALL accept fpu_done only in WAIT_FPU and ignore it in all other states.
REQ-031 In TX_LOAD, if tx_busy = 0, SHALL drive tx_data = the current response byte (MSB byte first), assert tx_en for one cycle and go to TX_WAIT_HI.
REQ-032 In TX_LOAD, if tx_busy = 1, SHALL wait with tx_en = 0.
REQ-033 In TX_WAIT_HI, SHALL wait for tx_busy = 1, then go to TX_WAIT_LO.
REQ-034 In TX_WAIT_LO, on tx_busy = 0, SHALL decrement the remaining-byte count.
REQ-035 From TX_WAIT_LO, SHALL return to TX_LOAD if bytes remain, else go to RX.
REQ-036 SHALL hold tx_data stable from tx_en assertion until tx_busy falls.
REQ-037 SHALL ignore byte strobes in every state except RX; such bytes are dropped and not buffered.
REQ-038 A strobe in the same cycle the timeout fires SHALL take priority: the byte is stored as frame byte count, and no err pulse is generated.

Reset
REQ-039 While reset = 1, SHALL drive state = RX, count = 0, idle counter = 0, rx_busy_d = 0.
REQ-040 While reset = 1, SHALL drive tx_data = 0, tx_en = 0, fpu_start = 0, fpu_op = 0, fpu_a = 0, fpu_b = 0, busy = 0, err = 0.
REQ-041 Reset asserted mid-frame, mid-FPU or mid-transmit SHALL abort the operation immediately; a later fpu_done SHALL be ignored.

Verification
REQ-042 Frame 00 3F800000 40000000 -> fpu_op = 0, fpu_a = 3F800000, fpu_b = 40000000, one fpu_start pulse.
REQ-043 Scenario REQ-042 with fpu_result = 40400000 -> tx bytes 40,40,00,00 in order; exactly 4 tx_en pulses; then busy = 0.
REQ-044 Opcode byte 07 followed by 8 bytes -> err pulse, single tx byte EE, no fpu_start.
REQ-045 Three bytes, then silence for TIMEOUT_CYCLES -> one err pulse, count = 0; the next full frame is processed correctly.
REQ-046 tx_busy held high for 50 cycles before the first response byte -> tx_en is delayed until tx_busy = 0; no byte lost.
REQ-047 Reset asserted during WAIT_FPU, then fpu_done pulsed -> all outputs at reset values; no tx_en.
